// File: rtl/debug_monitor_pkg.sv
// Shared types for the debug monitor: run-control state
// encoding and the default probe channel map.
package debug_monitor_pkg;

  // Run-control states.
  //   HALTED : CPU frozen, waiting for run or step
  //   RUN    : free-running until breakpoint or run drop
  //   STEP   : exactly one enabled cycle, then HALTED
  //   BREAK  : stopped on PC breakpoint, sticky flag set
  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    BREAK  = 2'd3
  } state_t;

  // Default probe channel map
  localparam int CH_INSTR = 0;
  localparam int CH_RS1   = 1;
  localparam int CH_RS2   = 2;
  localparam int CH_PC    = 3;

  // Width of a selector over n items, never below 1 bit.
  function automatic int selWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debug_monitor_trace_ram.sv
// Trace storage: DEPTH x DW, one write port, one
// synchronous read port with read-before-write behaviour.
//
// Ports:
//   clock  in   system clock
//   we     in   write enable
//   wAddr  in   write address
//   wData  in   write data (full probe vector)
//   rAddr  in   read address, sampled every cycle
//   rData  out  registered read data, old contents on
//               a same-cycle write to the same address
module debug_monitor_trace_ram #(
  parameter int DEPTH = 16,
  parameter int DW    = 128,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] wAddr,
  input  logic [DW-1:0] wData,
  input  logic [AW-1:0] rAddr,
  output logic [DW-1:0] rData
);

  logic [DW-1:0] mem [DEPTH];

  // Both ports update with non-blocking assignments on
  // the same edge, so a colliding read returns old data.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[wAddr] <= wData;
    end
    rData <= mem[rAddr];
  end

endmodule

// File: rtl/debug_monitor.sv
// Run-control and trace unit between the board top level
// and the datapath.
//
// Gates CPU progress through oCpuEnable (halt, single
// step, free run, one PC breakpoint) and records NCH
// probe channels per executed cycle in a circular trace
// buffer that can be read back while halted.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high
//   iRun         in   level, requests free-run
//   iStep        in   step request, rising edge used
//   iBreakEn     in   enables PC breakpoint compare
//   iBreakAddr   in   breakpoint PC
//   iPC          in   PC of instruction about to run
//   iProbe       in   channel k at [k*WIDTH +: WIDTH]
//   iTraceClr    in   clears trace pointer and count
//   iTraceRdIdx  in   read index, 0 = oldest entry
//   iTraceRdCh   in   channel to read
//   oCpuEnable   out  datapath clock-enable
//   oHalted      out  high in HALTED or BREAK
//   oBreakHit    out  sticky breakpoint flag
//   oTraceData   out  read data, 1-cycle latency
//   oTraceCount  out  valid entries, saturates at DEPTH
//   oCycles      out  enabled-cycle counter, wraps
module debug_monitor
  import debug_monitor_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = selWidth(NCH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iRun,
  input  logic               iStep,
  input  logic               iBreakEn,
  input  logic [WIDTH-1:0]   iBreakAddr,
  input  logic [WIDTH-1:0]   iPC,
  input  logic [NCH*WIDTH-1:0] iProbe,
  input  logic               iTraceClr,
  input  logic [AW-1:0]      iTraceRdIdx,
  input  logic [CW-1:0]      iTraceRdCh,
  output logic               oCpuEnable,
  output logic               oHalted,
  output logic               oBreakHit,
  output logic [WIDTH-1:0]   oTraceData,
  output logic [AW:0]        oTraceCount,
  output logic [CNT_W-1:0]   oCycles
);

  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
  localparam logic [CW:0] NCH_L = (CW+1)'(NCH);

  state_t state;

  logic stepQ;
  logic stepReq;
  logic brk;
  logic cpuEn;
  logic traceWe;

  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdAddr;
  logic          rdOk;
  logic          rdOkQ;
  logic [CW-1:0] rdChQ;

  logic [NCH*WIDTH-1:0] rdWord;

  // Edge register resets to 1 so a step button held
  // through reset does not produce a step afterwards.
  assign stepReq = iStep & ~stepQ;

  assign brk = iBreakEn & (iPC == iBreakAddr);

  // Enable is combinational so a breakpoint blocks the
  // very instruction sitting at iBreakAddr.
  always_comb begin
    cpuEn = 1'b0;
    unique case (state)
      STEP:    cpuEn = 1'b1;
      RUN:     cpuEn = ~brk;
      default: cpuEn = 1'b0;
    endcase
    if (reset) begin
      cpuEn = 1'b0;
    end
  end

  assign oCpuEnable = cpuEn;

  // Run-control FSM with registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= HALTED;
      oHalted   <= 1'b1;
      oBreakHit <= 1'b0;
      stepQ     <= 1'b1;
    end else begin
      stepQ <= iStep;
      unique case (state)
        HALTED: begin
          if (stepReq) begin
            state   <= STEP;
            oHalted <= 1'b0;
          end else if (iRun) begin
            state   <= RUN;
            oHalted <= 1'b0;
          end
        end
        STEP: begin
          state   <= HALTED;
          oHalted <= 1'b1;
        end
        RUN: begin
          if (brk) begin
            state     <= BREAK;
            oHalted   <= 1'b1;
            oBreakHit <= 1'b1;
          end else if (!iRun) begin
            state   <= HALTED;
            oHalted <= 1'b1;
          end
        end
        BREAK: begin
          if (stepReq) begin
            state     <= STEP;
            oHalted   <= 1'b0;
            oBreakHit <= 1'b0;
          end else if (!iRun) begin
            state <= HALTED;
          end
        end
        default: begin
          state   <= HALTED;
          oHalted <= 1'b1;
        end
      endcase
    end
  end

  // Clear wins over a same-cycle write: the entry is
  // dropped rather than landing after the clear.
  assign traceWe = cpuEn & ~iTraceClr;

  always_ff @(posedge clock) begin
    if (reset || iTraceClr) begin
      wrPtr       <= '0;
      oTraceCount <= '0;
    end else if (cpuEn) begin
      wrPtr <= wrPtr + AW'(1);
      if (oTraceCount != FULL) begin
        oTraceCount <= oTraceCount + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      oCycles <= '0;
    end else if (cpuEn) begin
      oCycles <= oCycles + CNT_W'(1);
    end
  end

  // Oldest entry sits count slots behind the write
  // pointer; when full the low bits of count are zero
  // and the oldest entry is at wrPtr itself.
  assign rdAddr = wrPtr - oTraceCount[AW-1:0]
                + iTraceRdIdx;

  assign rdOk = ({1'b0, iTraceRdIdx} < oTraceCount)
              & ({1'b0, iTraceRdCh} < NCH_L);

  always_ff @(posedge clock) begin
    if (reset) begin
      rdOkQ <= 1'b0;
      rdChQ <= '0;
    end else begin
      rdOkQ <= rdOk;
      rdChQ <= iTraceRdCh;
    end
  end

  debug_monitor_trace_ram #(
    .DEPTH (DEPTH),
    .DW    (NCH*WIDTH)
  ) uRam (
    .clock (clock),
    .we    (traceWe),
    .wAddr (wrPtr),
    .wData (iProbe),
    .rAddr (rdAddr),
    .rData (rdWord)
  );

  // Channel select on the registered RAM word; invalid
  // index or channel reads back as zero.
  always_comb begin
    oTraceData = '0;
    for (int k = 0; k < NCH; k++) begin
      if (rdOkQ && rdChQ == CW'(k)) begin
        oTraceData = rdWord[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_debug_monitor.sv
// Self-checking bench for debug_monitor: directed
// scenarios plus random traffic against a queue model.
module tb_debug_monitor;

  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int DEPTH = 16;
  localparam int CNT_W = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = 2;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 iRun;
  logic                 iStep;
  logic                 iBreakEn;
  logic [WIDTH-1:0]     iBreakAddr;
  logic [WIDTH-1:0]     iPC;
  logic [NCH*WIDTH-1:0] iProbe;
  logic                 iTraceClr;
  logic [AW-1:0]        iTraceRdIdx;
  logic [CW-1:0]        iTraceRdCh;
  logic                 oCpuEnable;
  logic                 oHalted;
  logic                 oBreakHit;
  logic [WIDTH-1:0]     oTraceData;
  logic [AW:0]          oTraceCount;
  logic [CNT_W-1:0]     oCycles;

  debug_monitor #(
    .WIDTH (WIDTH),
    .NCH   (NCH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .iRun        (iRun),
    .iStep       (iStep),
    .iBreakEn    (iBreakEn),
    .iBreakAddr  (iBreakAddr),
    .iPC         (iPC),
    .iProbe      (iProbe),
    .iTraceClr   (iTraceClr),
    .iTraceRdIdx (iTraceRdIdx),
    .iTraceRdCh  (iTraceRdCh),
    .oCpuEnable  (oCpuEnable),
    .oHalted     (oHalted),
    .oBreakHit   (oBreakHit),
    .oTraceData  (oTraceData),
    .oTraceCount (oTraceCount),
    .oCycles     (oCycles)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference model: mode names follow the run-control
  // rules; the trace is an ordered queue, oldest first.
  localparam int M_HALT = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_BRK  = 3;

  int                   mode;
  bit                   prevStep;
  bit                   hit;
  int unsigned          cyc;
  logic [NCH*WIDTH-1:0] q[$];
  logic [WIDTH-1:0]     expData;
  bit                   lastEn;
  int                   enCount;

  function automatic logic [NCH*WIDTH-1:0] mkProbe(
    input logic [WIDTH-1:0] c0);
    return {iPC, WIDTH'($urandom), WIDTH'($urandom), c0};
  endfunction

  // One clock: inputs were set at the current negedge.
  task automatic cycle();
    bit brk;
    bit sr;
    bit en;
    logic [NCH*WIDTH-1:0] w;
    #1;
    brk = iBreakEn && (iPC == iBreakAddr);
    sr  = iStep && !prevStep;
    en  = !reset
        && (mode == M_STEP || (mode == M_RUN && !brk));
    chk("cpuEnable", oCpuEnable, en);
    lastEn = en;
    if (oCpuEnable) enCount++;
    if (reset) begin
      mode     = M_HALT;
      prevStep = 1'b1;
      hit      = 1'b0;
      cyc      = 0;
      q.delete();
      expData  = '0;
    end else begin
      expData = '0;
      if (iTraceRdIdx < q.size()
          && int'(iTraceRdCh) < NCH) begin
        w = q[iTraceRdIdx];
        expData = w[int'(iTraceRdCh)*WIDTH +: WIDTH];
      end
      if (en) cyc++;
      if (iTraceClr) begin
        q.delete();
      end else if (en) begin
        q.push_back(iProbe);
        if (q.size() > DEPTH) void'(q.pop_front());
      end
      case (mode)
        M_HALT: begin
          if (sr) mode = M_STEP;
          else if (iRun) mode = M_RUN;
        end
        M_STEP: mode = M_HALT;
        M_RUN: begin
          if (brk) begin
            mode = M_BRK;
            hit  = 1'b1;
          end else if (!iRun) begin
            mode = M_HALT;
          end
        end
        default: begin
          if (sr) begin
            mode = M_STEP;
            hit  = 1'b0;
          end else if (!iRun) begin
            mode = M_HALT;
          end
        end
      endcase
      prevStep = iStep;
    end
    @(posedge clock);
    @(negedge clock);
    chk("halted", oHalted,
        (mode == M_HALT || mode == M_BRK));
    chk("breakHit", oBreakHit, hit);
    chk("cycles", oCycles, cyc % (1 << CNT_W));
    chk("traceCount", oTraceCount, q.size());
    chk("traceData", oTraceData, expData);
  endtask

  int n;

  initial begin
    reset       = 1'b1;
    iRun        = 1'b0;
    iStep       = 1'b1;
    iBreakEn    = 1'b0;
    iBreakAddr  = '0;
    iPC         = '0;
    iProbe      = '0;
    iTraceClr   = 1'b0;
    iTraceRdIdx = '0;
    iTraceRdCh  = '0;
    mode        = M_HALT;
    prevStep    = 1'b1;
    hit         = 1'b0;
    cyc         = 0;
    expData     = '0;
    lastEn      = 1'b0;
    enCount     = 0;
    @(negedge clock);

    // Reset with step held: nothing may execute.
    repeat (3) cycle();
    reset = 1'b0;
    repeat (3) cycle();
    chk("rstEnables", enCount, 0);
    chk("rstCycles", oCycles, 0);
    chk("rstHalted", oHalted, 1);

    // Single step from HALTED.
    iStep = 1'b0;
    cycle();
    iStep  = 1'b1;
    iProbe = mkProbe(32'h1);
    cycle();
    iStep = 1'b0;
    cycle();
    cycle();
    chk("stepEnables", enCount, 1);
    chk("stepCycles", oCycles, 1);
    chk("stepCount", oTraceCount, 1);

    // Run into a breakpoint at 0x10.
    iRun       = 1'b1;
    iBreakEn   = 1'b1;
    iBreakAddr = 32'h10;
    iPC        = 32'h0;
    enCount    = 0;
    for (int g = 0; g < 20 && mode != M_BRK; g++) begin
      iProbe = mkProbe(iPC);
      cycle();
      if (lastEn) iPC += 4;
    end
    chk("brkEnables", enCount, 4);
    chk("brkHit", oBreakHit, 1);
    chk("brkPcHeld", iPC, 32'h10);
    cycle();
    chk("brkStays", oHalted, 1);
    iRun  = 1'b0;
    iStep = 1'b1;
    cycle();
    iStep = 1'b0;
    cycle();
    if (lastEn) iPC += 4;
    chk("stepOverBrk", enCount, 5);
    chk("brkHitClr", oBreakHit, 0);
    cycle();

    // Fill past DEPTH with ch0 = enabled cycle number.
    iBreakEn  = 1'b0;
    iTraceClr = 1'b1;
    cycle();
    iTraceClr = 1'b0;
    n = 0;
    for (int g = 0; g < 40 && n < 20; g++) begin
      iRun   = (n < 19);
      iProbe = mkProbe(WIDTH'(n + 1));
      cycle();
      if (lastEn) n++;
    end
    chk("fullCount", oTraceCount, DEPTH);
    iTraceRdIdx = 0;
    iTraceRdCh  = 0;
    cycle();
    chk("idx0", oTraceData, 5);
    iTraceRdIdx = 15;
    cycle();
    chk("idx15", oTraceData, 20);
    iTraceRdCh = 3;
    cycle();

    // Clear during RUN, then one write lands at idx0.
    iRun = 1'b1;
    repeat (3) cycle();
    iTraceClr = 1'b1;
    cycle();
    chk("clrCount", oTraceCount, 0);
    iTraceClr = 1'b0;
    iRun      = 1'b0;
    iProbe    = mkProbe(32'hAA);
    cycle();
    iTraceRdIdx = 0;
    iTraceRdCh  = 0;
    cycle();
    chk("clrIdx0", oTraceData, 32'hAA);
    iTraceRdIdx = 3;
    cycle();
    chk("clrIdx3", oTraceData, 0);

    // Step and run rising together from HALTED.
    enCount = 0;
    iStep   = 1'b1;
    iRun    = 1'b1;
    cycle();
    iStep = 1'b0;
    cycle();
    chk("bothStep", enCount, 1);
    repeat (3) cycle();
    iRun = 1'b0;
    cycle();
    cycle();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      reset       = ($urandom_range(0, 699) == 0);
      iRun        = ($urandom_range(0, 9) < 7);
      iStep       = ($urandom_range(0, 3) == 0);
      iBreakEn    = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 15) == 0)
        iBreakAddr = iPC + 4 * $urandom_range(1, 4);
      if ($urandom_range(0, 31) == 0)
        iPC = WIDTH'($urandom_range(0, 63) * 4);
      iTraceClr   = ($urandom_range(0, 59) == 0);
      iTraceRdIdx = AW'($urandom);
      iTraceRdCh  = CW'($urandom);
      iProbe      = mkProbe(WIDTH'($urandom));
      cycle();
      if (lastEn) iPC += 4;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
